// File: rtl/rcc_eth_clk_mode_seq.sv
// ETH MII/RMII kernel-clock mode-change sequencer: gates the tx/rx kernel clocks,
// swaps the speed/interface selects while gated, waits for the switch to settle, then releases.
module rcc_eth_clk_mode_seq #(
    parameter int GATE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 64,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic req_fes,
    input  logic req_epis_2,
    output logic eth_rcc_fes,
    output logic eth_rcc_epis_2,
    output logic eth_clk_force_off,
    output logic busy,
    output logic done,
    output logic pend
);

    // state   | meaning
    // IDLE    | clocks running, waiting for a request (or a request queued at RELEASE exit)
    // GATE    | force_off held while in-flight kernel clock edges drain
    // SWITCH  | load the latched target into the select outputs
    // SETTLE  | glitch-free switch settles, force_off still held
    // RELEASE | release gates and pulse done, or chain into a queued differing request

    typedef enum logic [2:0] {IDLE, GATE, SWITCH, SETTLE, RELEASE} state_t;

    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             tgt_fes;
    logic             tgt_epis_2;
    logic             pend_fes;
    logic             pend_epis_2;
    logic             eff_fes;
    logic             eff_epis_2;

    // In IDLE a fresh request overrides anything left in the pending slot.
    always_comb begin
        eff_fes    = pend_fes;
        eff_epis_2 = pend_epis_2;
        if (req) begin
            eff_fes    = req_fes;
            eff_epis_2 = req_epis_2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            tgt_fes           <= 1'b0;
            tgt_epis_2        <= 1'b0;
            pend_fes          <= 1'b0;
            pend_epis_2       <= 1'b0;
            pend              <= 1'b0;
            eth_rcc_fes       <= 1'b0;
            eth_rcc_epis_2    <= 1'b0;
            eth_clk_force_off <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req || pend) begin
                        pend <= 1'b0;
                        if ({eff_fes, eff_epis_2} == {eth_rcc_fes, eth_rcc_epis_2}) begin
                            done <= 1'b1;
                        end else begin
                            tgt_fes           <= eff_fes;
                            tgt_epis_2        <= eff_epis_2;
                            cnt               <= GATE_LOAD;
                            eth_clk_force_off <= 1'b1;
                            busy              <= 1'b1;
                            state             <= GATE;
                        end
                    end
                end
                GATE: begin
                    if (cnt == '0) state <= SWITCH;
                    else           cnt   <= cnt - 1'b1;
                end
                SWITCH: begin
                    eth_rcc_fes    <= tgt_fes;
                    eth_rcc_epis_2 <= tgt_epis_2;
                    cnt            <= SETTLE_LOAD;
                    state          <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == '0) state <= RELEASE;
                    else           cnt   <= cnt - 1'b1;
                end
                RELEASE: begin
                    pend <= 1'b0;
                    if (pend && ({pend_fes, pend_epis_2} != {eth_rcc_fes, eth_rcc_epis_2})) begin
                        tgt_fes    <= pend_fes;
                        tgt_epis_2 <= pend_epis_2;
                        cnt        <= GATE_LOAD;
                        state      <= GATE;
                    end else begin
                        eth_clk_force_off <= 1'b0;
                        busy              <= 1'b0;
                        done              <= 1'b1;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Capture while busy (including the RELEASE cycle); latest request wins.
            if (req && state != IDLE) begin
                pend        <= 1'b1;
                pend_fes    <= req_fes;
                pend_epis_2 <= req_epis_2;
            end
        end
    end

endmodule

// File: tb/tb_rcc_eth_clk_mode_seq.sv
// Bench for rcc_eth_clk_mode_seq: vector table on a 1/1 instance, directed and random
// sequences on a default instance checked every cycle against a timestamp-based model.
module tb_rcc_eth_clk_mode_seq;

    localparam int G = 4;
    localparam int S = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, req_a, rf_a, re_a;
    logic fes_a, epis_a, fo_a, busy_a, done_a, pend_a;
    logic rst_b, req_b, rf_b, re_b;
    logic fes_b, epis_b, fo_b, busy_b, done_b, pend_b;

    rcc_eth_clk_mode_seq #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .req_fes(rf_a), .req_epis_2(re_a),
        .eth_rcc_fes(fes_a), .eth_rcc_epis_2(epis_a), .eth_clk_force_off(fo_a),
        .busy(busy_a), .done(done_a), .pend(pend_a));

    rcc_eth_clk_mode_seq #(.GATE_CYCLES(1), .SETTLE_CYCLES(1), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .req_fes(rf_b), .req_epis_2(re_b),
        .eth_rcc_fes(fes_b), .eth_rcc_epis_2(epis_b), .eth_clk_force_off(fo_b),
        .busy(busy_b), .done(done_b), .pend(pend_b));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Selects must only move while the gates are forced (reset restore excepted).
    logic       rst_seen_a = 1'b1;
    logic [1:0] sel_a_q = 2'bxx;
    logic [1:0] sel_b_q = 2'bxx;
    always @(posedge clk) rst_seen_a <= rst_a;
    always @(negedge clk) begin
        if (!$isunknown(sel_a_q) && ({fes_a, epis_a} != sel_a_q) && !rst_seen_a)
            chk("sel_change_gated_a", 32'(fo_a), 32'd1);
        if (!$isunknown(sel_b_q) && ({fes_b, epis_b} != sel_b_q))
            chk("sel_change_gated_b", 32'(fo_b), 32'd1);
        sel_a_q = {fes_a, epis_a};
        sel_b_q = {fes_b, epis_b};
    end

    // Model: a sequence is a start timestamp; select swap, release and done follow by arithmetic.
    bit       m_active, m_done, m_pend;
    bit [1:0] m_app, m_tgt, m_pp;
    int       m_s, mc;

    task automatic model_step(input logic r, input logic q, input logic f, input logic e);
        bit       n_done;
        bit [1:0] rp, eff;
        rp = {f, e};
        n_done = 0;
        if (r) begin
            m_active = 0; m_done = 0; m_pend = 0; m_app = 0; m_tgt = 0; m_pp = 0;
            mc++;
            return;
        end
        if (!m_active) begin
            if (q || m_pend) begin
                eff = q ? rp : m_pp;
                m_pend = 0;
                if (eff == m_app) n_done = 1;
                else begin m_active = 1; m_s = mc + 1; m_tgt = eff; end
            end
        end else begin
            if (mc == m_s + G + S + 1) begin
                if (m_pend && m_pp != m_app) begin
                    m_s = mc + 1; m_tgt = m_pp; m_pend = 0;
                end else begin
                    m_active = 0; n_done = 1; m_pend = 0;
                end
            end
            if (q) begin m_pend = 1; m_pp = rp; end
        end
        if (m_active && (mc + 1 == m_s + G + 1)) m_app = m_tgt;
        m_done = n_done;
        mc++;
    endtask

    // One cycle on dut_a: compare current outputs with model, then drive inputs.
    task automatic cyc_a(input logic r, input logic q, input logic f, input logic e);
        chk("model_a", 32'({fes_a, epis_a, fo_a, busy_a, done_a, pend_a}),
            32'({m_app, m_active, m_active, m_done, m_pend}));
        rst_a = r; req_a = q; rf_a = f; re_a = e;
        model_step(r, q, f, e);
        @(negedge clk);
    endtask

    typedef struct {
        logic       req;
        logic [1:0] pair;
        logic [5:0] exp;   // {fes, epis_2, force_off, busy, done, pend}
    } vec_t;
    vec_t tbl[20];

    initial begin
        int done_at, fes_at, fo_cnt, dcnt, fo_low;
        tbl[0]  = '{1'b1, 2'b10, 6'b000000};
        tbl[1]  = '{1'b0, 2'b00, 6'b001100};
        tbl[2]  = '{1'b0, 2'b00, 6'b001100};
        tbl[3]  = '{1'b0, 2'b00, 6'b101100};
        tbl[4]  = '{1'b0, 2'b00, 6'b101100};
        tbl[5]  = '{1'b0, 2'b00, 6'b100010};
        tbl[6]  = '{1'b1, 2'b10, 6'b100000};
        tbl[7]  = '{1'b0, 2'b00, 6'b100010};
        tbl[8]  = '{1'b1, 2'b01, 6'b100000};
        tbl[9]  = '{1'b1, 2'b11, 6'b101100};
        tbl[10] = '{1'b0, 2'b00, 6'b101101};
        tbl[11] = '{1'b0, 2'b00, 6'b011101};
        tbl[12] = '{1'b0, 2'b00, 6'b011101};
        tbl[13] = '{1'b0, 2'b00, 6'b011100};
        tbl[14] = '{1'b0, 2'b00, 6'b011100};
        tbl[15] = '{1'b0, 2'b00, 6'b111100};
        tbl[16] = '{1'b1, 2'b11, 6'b111100};
        tbl[17] = '{1'b0, 2'b00, 6'b110011};
        tbl[18] = '{1'b0, 2'b00, 6'b110010};
        tbl[19] = '{1'b0, 2'b00, 6'b110000};

        rst_a = 1; req_a = 0; rf_a = 0; re_a = 0;
        rst_b = 1; req_b = 0; rf_b = 0; re_b = 0;
        @(negedge clk);
        @(negedge clk);
        rst_b = 0;

        // Short-parameter instance: vector table
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("vec_b[%0d]", i),
                32'({fes_b, epis_b, fo_b, busy_b, done_b, pend_b}), 32'(tbl[i].exp));
            req_b = tbl[i].req; rf_b = tbl[i].pair[1]; re_b = tbl[i].pair[0];
            @(negedge clk);
        end
        req_b = 0;

        // Default instance: model state matches a freshly reset DUT
        m_active = 0; m_done = 0; m_pend = 0; m_app = 0; m_tgt = 0; m_pp = 0; mc = 0; m_s = 0;
        chk("reset_outputs_a", 32'({fes_a, epis_a, fo_a, busy_a, done_a, pend_a}), 32'd0);

        // Basic change (0,0) -> (1,0)
        done_at = -1; fes_at = -1; fo_cnt = 0;
        cyc_a(0, 1, 1, 0);
        for (int k = 1; k <= 75; k++) begin
            if (done_a && done_at < 0) done_at = k;
            if (fes_a && fes_at < 0) fes_at = k;
            if (fo_a) fo_cnt++;
            if (k == 71) chk("fo_low_in_done_cycle", 32'(fo_a), 32'd0);
            chk("epis_stays_0", 32'(epis_a), 32'd0);
            cyc_a(0, 0, 0, 0);
        end
        chk("done_latency", 32'(done_at), 32'(G + S + 3));
        chk("sel_latency", 32'(fes_at), 32'(G + 2));
        chk("force_off_cycles", 32'(fo_cnt), 32'(G + S + 2));

        // No-change request
        cyc_a(0, 1, 1, 0);
        chk("nochange_done", 32'(done_a), 32'd1);
        chk("nochange_no_gate", 32'({fo_a, busy_a}), 32'd0);
        for (int k = 0; k < 5; k++) cyc_a(0, 0, 0, 0);

        // Queued: (0,1), then (1,1), then (1,0) while busy
        dcnt = 0; fo_low = 0; done_at = -1;
        for (int k = 0; k < 160; k++) begin
            if (done_a) begin dcnt++; if (done_at < 0) done_at = k; end
            if (k >= 1 && done_at < 0 && !fo_a) fo_low++;
            if (k == 11) chk("queued_pend", 32'(pend_a), 32'd1);
            if (k == 0)       cyc_a(0, 1, 0, 1);
            else if (k == 10) cyc_a(0, 1, 1, 1);
            else if (k == 20) cyc_a(0, 1, 1, 0);
            else              cyc_a(0, 0, 0, 0);
        end
        chk("queued_one_done", 32'(dcnt), 32'd1);
        chk("queued_no_release_glitch", 32'(fo_low), 32'd0);
        chk("queued_final_sel", 32'({fes_a, epis_a}), 32'b10);

        // Queued request equal to the newly applied pair
        dcnt = 0;
        for (int k = 0; k < 80; k++) begin
            if (done_a) dcnt++;
            if (k == G + S + 2) chk("eq_pend_at_release", 32'(pend_a), 32'd1);
            if (k == G + S + 3) chk("eq_pend_cleared", 32'(pend_a), 32'd0);
            if (k == 0 || k == 5) cyc_a(0, 1, 0, 1);
            else                  cyc_a(0, 0, 0, 0);
        end
        chk("eq_one_done", 32'(dcnt), 32'd1);

        // Reset held 2 cycles mid-SETTLE, then a fresh sequence
        for (int k = 0; k < 22; k++) begin
            if (k == 0)       cyc_a(0, 1, 1, 1);
            else if (k >= 20) cyc_a(1, 0, 0, 0);
            else              cyc_a(0, 0, 0, 0);
        end
        chk("mid_reset_outputs", 32'({fes_a, epis_a, fo_a, busy_a, done_a, pend_a}), 32'd0);
        for (int k = 0; k < 80; k++) begin
            if (k == 0) cyc_a(0, 1, 1, 1);
            else        cyc_a(0, 0, 0, 0);
        end
        chk("after_reset_sel", 32'({fes_a, epis_a}), 32'b11);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            logic r, q;
            r = ($urandom_range(0, 499) == 0);
            q = ($urandom_range(0, 7) == 0);
            cyc_a(r, q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
